// File: rtl/ahb_params_pkg.sv
// AHB-Lite encodings shared by the initiator and the team's AHB slaves.
// Also holds the size clamp and address alignment helpers.
package ahb_params;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  // Bus is 32 bits wide, so anything wider is a word.
  function automatic logic [2:0] clamp_size(
    input logic [2:0] sz
  );
    return (sz > HSIZE_WORD) ? HSIZE_WORD : sz;
  endfunction

  function automatic logic [1:0] align_lo(
    input logic [1:0] lo,
    input logic [2:0] sz
  );
    logic [1:0] r;
    r = lo;
    unique case (1'b1)
      (sz == HSIZE_HALF): r = {lo[1], 1'b0};
      (sz == HSIZE_WORD): r = 2'b00;
      default:            r = lo;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ahb_master_timeout.sv
// Wait-state watchdog: sticky flag after TIMEOUT_CYCLES stalled data-phase
// cycles. Only built with AHB_MASTER_TIMEOUT_EN.
module ahb_master_timeout #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic dp_valid,
  input  logic hready,
  input  logic timeout_clr,
  output logic timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
  logic          stall;

  always_comb begin
    stall     = dp_valid && !hready;
    cnt_d     = '0;
    if (stall) begin
      cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + CW'(1);
    end
    timeout_d = timeout_q || (stall && (cnt_q == LIMIT - CW'(1)));
    if (timeout_clr) begin
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;

endmodule

// File: rtl/ahb_lite_master.sv
// Pipelined single-transfer AHB-Lite initiator (NONSEQ SINGLE only).
// Optional wait-state watchdog via AHB_MASTER_TIMEOUT_EN.
module ahb_lite_master
  import ahb_params::*;
#(
  parameter int AW = 32
`ifdef AHB_MASTER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [2:0]    cmd_size,
  input  logic [31:0]   cmd_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] HADDR,
  output logic [1:0]    HTRANS,
  output logic [2:0]    HSIZE,
  output logic          HWRITE,
  output logic [2:0]    HBURST,
  output logic [3:0]    HPROT,
  output logic          HMASTLOCK,
  output logic [31:0]   HWDATA,
  input  logic [31:0]   HRDATA,
  input  logic          HREADY,
  input  logic          HRESP
`ifdef AHB_MASTER_TIMEOUT_EN
  , output logic        timeout
  , input  logic        timeout_clr
`endif
);

  logic          ap_valid_q, ap_valid_d;
  logic [AW-1:0] ap_addr_q, ap_addr_d;
  logic [2:0]    ap_size_q, ap_size_d;
  logic          ap_write_q, ap_write_d;
  logic [31:0]   ap_wdata_q, ap_wdata_d;
  logic          dp_valid_q, dp_valid_d;
  logic          dp_write_q, dp_write_d;
  logic [31:0]   dp_wdata_q, dp_wdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          accept;
  logic [2:0]    size_c;

  assign cmd_ready = !ap_valid_q || HREADY;

  always_comb begin
    accept      = cmd_valid && cmd_ready;
    size_c      = clamp_size(cmd_size);
    ap_valid_d  = ap_valid_q;
    ap_addr_d   = ap_addr_q;
    ap_size_d   = ap_size_q;
    ap_write_d  = ap_write_q;
    ap_wdata_d  = ap_wdata_q;
    dp_valid_d  = dp_valid_q;
    dp_write_d  = dp_write_q;
    dp_wdata_d  = dp_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    if (HREADY) begin
      ap_valid_d = 1'b0;
      dp_valid_d = ap_valid_q;
      dp_write_d = ap_write_q;
      // HWDATA keeps its last value outside write data phases.
      if (ap_valid_q && ap_write_q) begin
        dp_wdata_d = ap_wdata_q;
      end
      if (dp_valid_q) begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = (HRESP == HRESP_ERROR);
        rsp_rdata_d = dp_write_q ? '0 : HRDATA;
      end
    end
    if (accept) begin
      ap_valid_d = 1'b1;
      ap_addr_d  = {cmd_addr[AW-1:2],
                    align_lo(cmd_addr[1:0], size_c)};
      ap_size_d  = size_c;
      ap_write_d = cmd_write;
      ap_wdata_d = cmd_wdata;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap_valid_q  <= 1'b0;
      ap_addr_q   <= '0;
      ap_size_q   <= '0;
      ap_write_q  <= 1'b0;
      ap_wdata_q  <= '0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_wdata_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      ap_valid_q  <= ap_valid_d;
      ap_addr_q   <= ap_addr_d;
      ap_size_q   <= ap_size_d;
      ap_write_q  <= ap_write_d;
      ap_wdata_q  <= ap_wdata_d;
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      dp_wdata_q  <= dp_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign HTRANS    = ap_valid_q ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR     = ap_addr_q;
  assign HSIZE     = ap_size_q;
  assign HWRITE    = ap_write_q;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_DEFAULT;
  assign HMASTLOCK = 1'b0;
  assign HWDATA    = dp_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

`ifdef AHB_MASTER_TIMEOUT_EN
  ahb_master_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .dp_valid   (dp_valid_q),
    .hready     (HREADY),
    .timeout_clr(timeout_clr),
    .timeout    (timeout)
  );
`endif

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: AHB slave model plus response scoreboard.
// Timeout checks are built only with AHB_MASTER_TIMEOUT_EN.
module tb_ahb_lite_master;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [2:0]  cmd_size = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
`ifdef AHB_MASTER_TIMEOUT_EN
  logic        timeout;
  logic        timeout_clr = 1'b0;
`endif

  always #5 HCLK = ~HCLK;

  ahb_lite_master dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE),
    .HWRITE(HWRITE), .HBURST(HBURST), .HPROT(HPROT),
    .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
`ifdef AHB_MASTER_TIMEOUT_EN
    , .timeout(timeout), .timeout_clr(timeout_clr)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_cmd = 0;
  int n_rsp = 0;
  int n_drop = 0;
  int cyc = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int waits_of(input logic [31:0] a);
    if (a == 32'h204) return 2;
    if (a == 32'h400) return 1030;
    return 0;
  endfunction

  function automatic logic err_of(input logic [31:0] a);
    return a == 32'h300;
  endfunction

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    if (a == 32'h204) return 32'h1234_5678;
    return {a[15:0] ^ 16'h5A5A, 16'hC0DE};
  endfunction

  // Slave model
  logic        sl_act, sl_wr, sl_err, sl_ph;
  int          sl_wait;
  logic [31:0] sl_addr;

  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = 32'hBAD0_BAD0;
    if (sl_act) begin
      if (sl_err) begin
        HRESP  = 1'b1;
        HREADY = sl_ph;
      end else begin
        HREADY = (sl_wait == 0);
      end
      if (HREADY && !sl_wr) HRDATA = rdata_of(sl_addr);
    end
  end

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sl_act  <= 1'b0;
      sl_wr   <= 1'b0;
      sl_err  <= 1'b0;
      sl_ph   <= 1'b0;
      sl_wait <= 0;
      sl_addr <= '0;
    end else if (HREADY) begin
      sl_act  <= (HTRANS == 2'b10);
      sl_wr   <= HWRITE;
      sl_addr <= HADDR;
      sl_err  <= err_of(HADDR);
      sl_ph   <= 1'b0;
      sl_wait <= waits_of(HADDR);
    end else begin
      sl_ph <= 1'b1;
      if (sl_wait > 0) sl_wait <= sl_wait - 1;
    end
  end

  always @(posedge HCLK) cyc <= cyc + 1;

  // Scoreboards and bus log
  logic [32:0] exp_q[$];
  logic [31:0] wq[$];
  typedef struct {
    int          c;
    logic [31:0] a;
    logic [2:0]  s;
  } bus_t;
  bus_t blog[$];

  always @(negedge HCLK) begin
    if (HRESETn && HTRANS == 2'b10)
      blog.push_back('{cyc, HADDR, HSIZE});
    if (HRESETn && sl_act && sl_wr && HREADY) begin
      if (wq.size() == 0) chk("wdata_extra", 1, 0);
      else chk("hwdata", HWDATA, wq.pop_front());
    end
    if (rsp_valid) begin
      logic [32:0] e;
      n_rsp++;
      if (exp_q.size() == 0) begin
        chk("rsp_extra", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_err", rsp_err, e[32]);
        chk("rsp_rdata", rsp_rdata, e[31:0]);
      end
    end
  end

  task automatic send(input logic w, input logic [31:0] a,
                      input logic [2:0] s, input logic [31:0] d);
    int n;
    logic [31:0] ea;
    logic [2:0] es;
    n = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_size  = s;
    cmd_wdata = d;
    #1;
    while (!cmd_ready && n < 2000) begin
      @(negedge HCLK);
      #1;
      n++;
    end
    chk("accept", cmd_ready, 1);
    es = (s > 3'd2) ? 3'd2 : s;
    ea = a;
    if (es == 3'd1) ea[0] = 1'b0;
    if (es == 3'd2) ea[1:0] = 2'b00;
    exp_q.push_back({err_of(ea), w ? 32'h0 : rdata_of(ea)});
    if (w) wq.push_back(d);
    n_cmd++;
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    repeat (n) @(negedge HCLK);
  endtask

  initial begin
    logic [31:0] bb_a[3];
    logic [2:0]  bb_s[3];
    int n;
    bb_a[0] = 32'h0; bb_a[1] = 32'h4; bb_a[2] = 32'h7;
    bb_s[0] = 3'd2;  bb_s[1] = 3'd2;  bb_s[2] = 3'd0;

    repeat (2) @(negedge HCLK);
    chk("rst_htrans", HTRANS, 0);
    chk("rst_haddr", HADDR, 0);
    chk("rst_hwdata", HWDATA, 0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("consts", {HBURST, HPROT, HMASTLOCK}, {3'b000, 4'b0011, 1'b0});
    HRESETn = 1'b1;
    idle(2);

    // 1: single write
    send(1, 32'h100, 3'd2, 32'hDEAD_BEEF);
    cmd_valid = 1'b0;
    chk("t1_htrans", HTRANS, 2);
    chk("t1_haddr", HADDR, 32'h100);
    chk("t1_hwrite", HWRITE, 1);
    @(negedge HCLK);
    chk("t1_hwdata", HWDATA, 32'hDEAD_BEEF);
    chk("t1_htrans_idle", HTRANS, 0);
    chk("t1_rsp_early", rsp_valid, 0);
    @(negedge HCLK);
    chk("t1_rsp", rsp_valid, 1);
    idle(3);

    // 2: read with two wait states, next command stuck in AP
    send(0, 32'h204, 3'd2, 0);
    send(0, 32'h208, 3'd2, 0);
    cmd_valid = 1'b0;
    chk("t2_hready", HREADY, 0);
    chk("t2_haddr", HADDR, 32'h208);
    chk("t2_ready", cmd_ready, 0);
    @(negedge HCLK);
    chk("t2_haddr_hold", HADDR, 32'h208);
    chk("t2_htrans_hold", HTRANS, 2);
    chk("t2_ready_hold", cmd_ready, 0);
    chk("t2_no_rsp", rsp_valid, 0);
    idle(5);

    // 3: back-to-back
    blog.delete();
    send(1, 32'h0, 3'd2, 32'h1111_1111);
    send(0, 32'h4, 3'd2, 0);
    send(1, 32'h7, 3'd0, 32'hAB00_0000);
    idle(5);
    chk("t3_nonseq_cnt", blog.size(), 3);
    if (blog.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("t3_haddr", blog[i].a, bb_a[i]);
        chk("t3_hsize", blog[i].s, bb_s[i]);
        chk("t3_cycle", blog[i].c - blog[0].c, i);
      end
    end

    // 4: error on read with a write pending in AP
    send(0, 32'h300, 3'd2, 0);
    send(1, 32'h304, 3'd2, 32'h55AA_55AA);
    cmd_valid = 1'b0;
    chk("t4_err1_hready", HREADY, 0);
    chk("t4_err1_ready", cmd_ready, 0);
    chk("t4_ap_haddr", HADDR, 32'h304);
    idle(6);

    // 5: misaligned / oversize
    send(0, 32'h103, 3'd1, 0);
    chk("t5_haddr_half", HADDR, 32'h102);
    chk("t5_hsize_half", HSIZE, 3'd1);
    send(0, 32'h10B, 3'd3, 0);
    chk("t5_haddr_big", HADDR, 32'h108);
    chk("t5_hsize_big", HSIZE, 3'd2);
    idle(4);

    // 6: reset during a wait state
    send(0, 32'h204, 3'd2, 0);
    send(0, 32'h208, 3'd2, 0);
    cmd_valid = 1'b0;
    chk("t6_in_wait", HREADY, 0);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("t6_htrans_async", HTRANS, 0);
    n_drop += exp_q.size();
    exp_q.delete();
    wq.delete();
    @(negedge HCLK);
    chk("t6_rst_rsp", rsp_valid, 0);
    chk("t6_rst_hwdata", HWDATA, 0);
    chk("t6_rst_haddr", HADDR, 0);
    HRESETn = 1'b1;
    idle(5);
    chk("t6_post_htrans", HTRANS, 0);

`ifdef AHB_MASTER_TIMEOUT_EN
    chk("to_init", timeout, 0);
    send(0, 32'h400, 3'd2, 0);
    cmd_valid = 1'b0;
    repeat (1000) @(negedge HCLK);
    chk("to_early", timeout, 0);
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge HCLK);
      n++;
    end
    chk("to_rsp_seen", rsp_valid, 1);
    chk("to_set", timeout, 1);
    idle(3);
    chk("to_sticky", timeout, 1);
    timeout_clr = 1'b1;
    @(negedge HCLK);
    timeout_clr = 1'b0;
    chk("to_clr", timeout, 0);
    idle(2);
`endif

    n = 0;
    chk("sb_empty", exp_q.size() + wq.size(), n);
    chk("rsp_count", n_rsp, n_cmd - n_drop);
    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
